// File: rtl/imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// imm_ext_pipe
//
// Purpose:
//    Immediate extension stage with a 2-entry skid pipeline. Each accepted
//    item is extended according to in_mode before storage:
//       mode 00 : in_data passed through unchanged
//       mode 01 : in_data[FW1-1:0] sign-extended to WIDTH
//       mode 10 : in_data[FW2-1:0] sign-extended to WIDTH
//       mode 11 : in_data[FW3-1:0] sign-extended to WIDTH
//    The pipeline holds up to two items: the output register and one skid
//    register. in_ready is a register, so out_ready has no combinational
//    path to in_ready.
//
// Optional feature (macro IMM_EXT_SHL1_EN):
//    Adds input in_shl. When in_shl is 1 the extended value is shifted left
//    by one (bit 0 = 0, MSB dropped). Without the macro the port is absent.
//
// Parameters:
//    WIDTH : data path width
//    FW1   : source field width for mode 01 (1..WIDTH-1)
//    FW2   : source field width for mode 10 (1..WIDTH-1)
//    FW3   : source field width for mode 11 (1..WIDTH-1)
//
// Ports:
//    clk       : clock, rising edge
//    rst       : asynchronous active-high reset
//    in_valid  : upstream item present
//    in_ready  : block accepts an item this cycle (registered)
//    in_data   : raw immediate
//    in_mode   : extension mode
//    in_shl    : shift-left-by-one request (only with IMM_EXT_SHL1_EN)
//    out_valid : extended item present (registered)
//    out_ready : downstream accepts an item
//    out_data  : extended immediate (registered)
// -----------------------------------------------------------------------------
module imm_ext_pipe #(
   parameter int WIDTH = 16,
   parameter int FW1   = 5,
   parameter int FW2   = 8,
   parameter int FW3   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
`ifdef IMM_EXT_SHL1_EN
   input  logic             in_shl,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   // Field widths outside 1..WIDTH-1 would make the replication counts
   // below zero or negative, so reject them at elaboration.
   generate
      if (FW1 < 1 || FW1 > WIDTH - 1) begin : g_bad_fw1
         $error("imm_ext_pipe: FW1 must be in 1..WIDTH-1");
      end
      if (FW2 < 1 || FW2 > WIDTH - 1) begin : g_bad_fw2
         $error("imm_ext_pipe: FW2 must be in 1..WIDTH-1");
      end
      if (FW3 < 1 || FW3 > WIDTH - 1) begin : g_bad_fw3
         $error("imm_ext_pipe: FW3 must be in 1..WIDTH-1");
      end
   endgenerate

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic [WIDTH-1:0] skid_reg, skid_next;
   logic             out_valid_reg, out_valid_next;
   logic             in_ready_reg, in_ready_next;

   logic             in_xfer;
   logic             out_xfer;
   logic [WIDTH-1:0] ext_val;
   logic [WIDTH-1:0] ext_final;

   assign in_xfer  = in_valid & in_ready_reg;
   assign out_xfer = out_valid_reg & out_ready;

   // Extension of the incoming item; only stored on an input transfer.
   always_comb begin
      ext_val = in_data;
      case (in_mode)
         2'b00:   ext_val = in_data;
         2'b01:   ext_val = {{(WIDTH-FW1){in_data[FW1-1]}}, in_data[FW1-1:0]};
         2'b10:   ext_val = {{(WIDTH-FW2){in_data[FW2-1]}}, in_data[FW2-1:0]};
         default: ext_val = {{(WIDTH-FW3){in_data[FW3-1]}}, in_data[FW3-1:0]};
      endcase
   end

`ifdef IMM_EXT_SHL1_EN
   assign ext_final = in_shl ? {ext_val[WIDTH-2:0], 1'b0} : ext_val;
`else
   assign ext_final = ext_val;
`endif

   // Next-state and datapath control.
   always_comb begin
      state_next    = state_reg;
      out_data_next = out_data_reg;
      skid_next     = skid_reg;
      case (state_reg)
         EMPTY: begin
            if (in_xfer) begin
               state_next    = HALF;
               out_data_next = ext_final;
            end
         end
         HALF: begin
            case ({in_xfer, out_xfer})
               2'b10: begin
                  // Output is stalled: park the new item in the skid slot.
                  state_next = FULL;
                  skid_next  = ext_final;
               end
               2'b01: state_next = EMPTY;
               2'b11: out_data_next = ext_final;
               default: ;
            endcase
         end
         FULL: begin
            // in_ready is low here, so only the output side can move.
            if (out_xfer) begin
               state_next    = HALF;
               out_data_next = skid_reg;
            end
         end
         default: state_next = EMPTY;
      endcase
      // Flags are registered copies derived from the next state so that
      // they are glitch-free and free of any path from out_ready.
      out_valid_next = (state_next != EMPTY);
      in_ready_next  = (state_next != FULL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= EMPTY;
         out_data_reg  <= '0;
         skid_reg      <= '0;
         out_valid_reg <= 1'b0;
         in_ready_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         out_data_reg  <= out_data_next;
         skid_reg      <= skid_next;
         out_valid_reg <= out_valid_next;
         in_ready_reg  <= in_ready_next;
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_ext_pipe
//
// Purpose:
//    Directed self-checking bench for imm_ext_pipe with default parameters.
//    Inputs change and outputs are sampled 1 time unit after each rising
//    edge. With IMM_EXT_SHL1_EN defined the shift feature is exercised too.
// -----------------------------------------------------------------------------
module tb_imm_ext_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic [1:0]  in_mode;
`ifdef IMM_EXT_SHL1_EN
   logic        in_shl;
`endif
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   imm_ext_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
`ifdef IMM_EXT_SHL1_EN
      .in_shl    (in_shl),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end else begin
         $display("ok   %s: value=%h", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one item with out_ready high; check it one edge later.
   task automatic send_chk(input string tag, input logic [1:0] mode,
                           input logic [15:0] data, input logic [15:0] exp);
      in_valid = 1'b1;
      in_mode  = mode;
      in_data  = data;
      step();
      in_valid = 1'b0;
      check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check_val({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_mode   = 2'b00;
      out_ready = 1'b0;
`ifdef IMM_EXT_SHL1_EN
      in_shl    = 1'b0;
`endif
      step();
      step();
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_out_data", {16'd0, out_data}, 32'd0);
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      step();
      check_val("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Extension modes, out_ready held high.
      out_ready = 1'b1;
      send_chk("m01_0010", 2'b01, 16'h0010, 16'hFFF0);
      send_chk("m00_8010", 2'b00, 16'h8010, 16'h8010);
      send_chk("m10_007F", 2'b10, 16'h007F, 16'h007F);
      send_chk("m11_0400", 2'b11, 16'h0400, 16'hFC00);
      send_chk("m11_F3FF", 2'b11, 16'hF3FF, 16'h03FF);
      send_chk("m01_000F", 2'b01, 16'hFF0F, 16'h000F);
      step();
      check_val("drain_valid", {31'd0, out_valid}, 32'd0);

      // Back-pressure: three items with out_ready low.
      out_ready = 1'b0;
      in_mode   = 2'b00;
      in_valid  = 1'b1;
      in_data   = 16'h1111;
      step();
      check_val("bp_a_ready", {31'd0, in_ready}, 32'd1);
      check_val("bp_a_data", {16'd0, out_data}, 32'h1111);
      in_data = 16'h2222;
      step();
      check_val("bp_b_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_b_data", {16'd0, out_data}, 32'h1111);
      in_data = 16'h3333;
      step();
      check_val("bp_c_held_ready", {31'd0, in_ready}, 32'd0);
      check_val("bp_c_held_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_c_held_data", {16'd0, out_data}, 32'h1111);
      out_ready = 1'b1;
      step();
      check_val("bp_out_b", {16'd0, out_data}, 32'h2222);
      check_val("bp_out_b_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check_val("bp_out_c", {16'd0, out_data}, 32'h3333);
      check_val("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
      step();
      check_val("bp_empty_valid", {31'd0, out_valid}, 32'd0);

      // Continuous streaming: ten items, no bubbles.
      for (int i = 1; i <= 10; i++) begin
         in_valid = 1'b1;
         in_mode  = 2'b00;
         in_data  = 16'(i * 16'h0101);
         step();
         check_val($sformatf("str%0d_valid", i), {31'd0, out_valid}, 32'd1);
         check_val($sformatf("str%0d_data", i), {16'd0, out_data},
                   32'(i * 16'h0101));
         check_val($sformatf("str%0d_ready", i), {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0;
      step();
      check_val("str_end_valid", {31'd0, out_valid}, 32'd0);

      // Fill to FULL, then reset in mid-cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hAAAA;
      step();
      in_data = 16'h5555;
      step();
      in_valid = 1'b0;
      check_val("full_in_ready", {31'd0, in_ready}, 32'd0);
      check_val("full_out_data", {16'd0, out_data}, 32'hAAAA);
      #2;
      rst = 1'b1;
      #1;
      check_val("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("arst_out_data", {16'd0, out_data}, 32'd0);
      check_val("arst_in_ready", {31'd0, in_ready}, 32'd0);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      check_val("arst_rel_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("arst_rel_valid", {31'd0, out_valid}, 32'd0);

`ifdef IMM_EXT_SHL1_EN
      in_shl = 1'b1;
      send_chk("shl_m10_0080", 2'b10, 16'h0080, 16'hFF00);
      send_chk("shl_m00_C001", 2'b00, 16'hC001, 16'h8002);
      in_shl = 1'b0;
      send_chk("noshl_m10_0080", 2'b10, 16'h0080, 16'hFF80);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the bench itself stalls.
   initial begin
      #100000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
